spi_burst_master: RTL and testbench



---
 rtl/spi_burst_pkg.sv | 22 ++
 rtl/spi_burst_rd_fifo.sv | 58 +++++
 rtl/spi_burst_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_burst_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_burst_pkg.sv
// Shared definitions for the SPI burst master.
//   state_t  : frame sequencer states
//   RW_READ  : value of the header R/W bit that selects a read burst
//   hdr_bits : number of header bits shifted before the data words
package spi_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    STALL,
    XFER,
    DONE
  } state_t;

  localparam logic RW_READ = 1'b1;

  // Header is the R/W bit followed by the full register address.
  function automatic int hdr_bits(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/spi_burst_rd_fifo.sv
// First-word-fall-through FIFO buffering read words from the serial side.
//   clk, rst   : IP clock, asynchronous active-high reset (flushes contents)
//   push       : write push_data this cycle
//   push_data  : word to store
//   pop        : consumer takes the head word this cycle (ignored when empty)
//   pop_data   : current head word
//   valid      : FIFO not empty
//   count      : occupancy, 0..DEPTH
module spi_burst_rd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push  = push && ((count != FULL) || do_pop);
  assign pop_data = mem[rptr];
  assign valid    = (count != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_burst_master.sv
// SPI master executing multi-word burst reads/writes from a single command.
// A frame is one header {R/W, address} followed by cmd_len+1 data words,
// all MSB-first, spi_clk idling low and each bit low phase then high phase.
//   cmd_valid/cmd_ready/cmd_read/cmd_addr/cmd_len : command handshake (IDLE only)
//   wr_valid/wr_ready/wr_data                     : write word stream
//   rd_valid/rd_ready/rd_data/rd_count            : read FIFO (FWFT) interface
//   busy, done                                    : frame status, done pulses once
//   spi_clk, serial_out, serial_in                : chip pins (SCLK, MOSI, MISO)
module spi_burst_master
  import spi_burst_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MAX_BURST  = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_read,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [$clog2(MAX_BURST)-1:0]  cmd_len,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   rd_count,
  output logic                          busy,
  output logic                          done,
  input  logic                          serial_in,
  output logic                          serial_out,
  output logic                          spi_clk
);

  localparam int HB    = hdr_bits(ADDR_W);
  localparam int SH_W  = (HB > DATA_W) ? HB : DATA_W;
  localparam int LEN_W = $clog2(MAX_BURST);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BC_W  = $clog2(SH_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0]  HDR_LAST  = BC_W'(HB - 1);
  localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [BC_W-1:0]     bit_cnt;
  logic [LEN_W-1:0]    word_cnt;
  logic [LEN_W-1:0]    len_q;
  logic                read_q;
  // Bits still to be sent after the one currently on serial_out.
  logic [SH_W-2:0]     tx_sh;
  // Bits of the read word received so far (its last bit goes straight to the FIFO).
  logic [DATA_W-2:0]   rx_sh;
  logic [DATA_W-1:0]   push_data;

  logic accept;
  logic is_read;
  logic shifting;
  logic phase_end;
  logic rise;
  logic fall;
  logic last_bit;
  logic bit_done;
  logic stall_go;
  logic push;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign is_read   = (read_q == RW_READ);

  assign shifting  = (state == HDR) || (state == XFER);
  assign phase_end = shifting && (div_cnt == DIV_LAST);
  assign rise      = phase_end && !spi_clk;
  assign fall      = phase_end && spi_clk;
  assign last_bit  = (state == HDR) ? (bit_cnt == HDR_LAST) : (bit_cnt == DATA_LAST);
  assign bit_done  = fall && last_bit;

  // A read word only starts once the FIFO has room for it, so the push below never hits a full FIFO.
  assign stall_go  = (state == STALL) && (is_read ? (rd_count < FIFO_FULL) : wr_valid);
  assign wr_ready  = (state == STALL) && !is_read && wr_valid;

  assign push_data = {rx_sh, serial_in};
  assign push      = rise && (state == XFER) && is_read && (bit_cnt == DATA_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HDR;
      HDR:     if (bit_done) state_nxt = STALL;
      STALL:   if (stall_go) state_nxt = XFER;
      XFER:    if (bit_done) state_nxt = (word_cnt == len_q) ? DONE : STALL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial clock generation, bit/word counting and MOSI; everything here
  // changes only at a falling spi_clk edge or while spi_clk is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_clk    <= 1'b0;
      serial_out <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      read_q     <= 1'b0;
      len_q      <= '0;
    end else if (accept) begin
      spi_clk    <= 1'b0;
      serial_out <= cmd_read;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      read_q     <= cmd_read;
      len_q      <= cmd_len;
    end else if (stall_go) begin
      serial_out <= is_read ? 1'b0 : wr_data[DATA_W-1];
      div_cnt    <= '0;
      bit_cnt    <= '0;
    end else if (shifting) begin
      if (phase_end) begin
        div_cnt <= '0;
        spi_clk <= ~spi_clk;
        if (fall) begin
          if (last_bit) begin
            bit_cnt    <= '0;
            serial_out <= 1'b0;
            if (state == XFER) word_cnt <= word_cnt + 1'b1;
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            serial_out <= tx_sh[SH_W-2];
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      tx_sh <= (SH_W-1)'(cmd_addr) << (SH_W - 1 - ADDR_W);
    else if (stall_go)
      tx_sh <= is_read ? '0 : ((SH_W-1)'(wr_data[DATA_W-2:0]) << (SH_W - DATA_W));
    else if (fall)
      tx_sh <= tx_sh << 1;
    if (rise && (state == XFER) && is_read)
      rx_sh <= push_data[DATA_W-2:0];
  end

  spi_burst_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .valid     (rd_valid),
    .count     (rd_count)
  );

endmodule

// File: tb/tb_spi_burst_master.sv
// Directed self-checking bench for spi_burst_master with a small SPI chip model.
module tb_spi_burst_master;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int MAX_BURST  = 16;
  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = $clog2(MAX_BURST);
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_read;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  rd_count;
  logic              busy;
  logic              done;
  logic              serial_in;
  logic              serial_out;
  logic              spi_clk;

  always #5 clk = ~clk;

  spi_burst_master #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_BURST  (MAX_BURST),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_read   (cmd_read),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_count   (rd_count),
    .busy       (busy),
    .done       (done),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .spi_clk    (spi_clk)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards and stimulus sources
  logic              exp_mosi [$];
  logic [DATA_W-1:0] exp_rd   [$];
  logic [DATA_W-1:0] wr_src   [$];
  logic [DATA_W-1:0] miso_mem [32];

  // Chip model: captures MOSI on spi_clk rises, advances MISO after each fall
  logic spi_prev = 1'b0;
  int   bitpos = 0;
  int   mosi_extra = 0;

  always @(posedge clk) begin
    if (rst) begin
      spi_prev = 1'b0;
      bitpos   = 0;
    end else begin
      if (spi_clk && !spi_prev) begin
        if (exp_mosi.size() == 0) mosi_extra++;
        else chk("mosi_bit", 32'(serial_out), 32'(exp_mosi.pop_front()));
      end
      if (!busy) bitpos = 0;
      else if (spi_prev && !spi_clk) bitpos++;
      spi_prev = spi_clk;
    end
  end

  always_comb begin
    serial_in = 1'b0;
    if (bitpos >= 9) serial_in = miso_mem[((bitpos - 9) / 8) % 32][7 - ((bitpos - 9) % 8)];
  end

  // Per-cycle bookkeeping
  int   cyc, wr_pulses, done_cnt, done_cyc, low_run, max_low, rd_pops, rd_extra;
  int   hold_word = -1;
  int   hold_len  = 0;
  logic wr_take   = 1'b0;
  logic rd_auto   = 1'b0;

  task automatic chk_rd();
    if (exp_rd.size() == 0) rd_extra++;
    else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
    rd_pops++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (wr_take) begin void'(wr_src.pop_front()); wr_pulses++; end
    wr_valid = (wr_src.size() > 0) && !((wr_pulses == hold_word) && (low_run < hold_len));
    wr_data  = (wr_src.size() > 0) ? wr_src[0] : '0;
    #1;
    wr_take = wr_ready;
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) done_cyc = cyc;
    end
    if (busy && !spi_clk) low_run++; else low_run = 0;
    if (low_run > max_low) max_low = low_run;
    rd_ready = 1'b0;
    if (rd_auto && rd_valid) begin chk_rd(); rd_ready = 1'b1; end
  endtask

  task automatic issue(input logic rd, input logic [ADDR_W-1:0] addr, input int len);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_len   = LEN_W'(len);
    exp_mosi.push_back(rd);
    for (int b = ADDR_W - 1; b >= 0; b--) exp_mosi.push_back(addr[b]);
    for (int w = 0; w <= len; w++)
      for (int b = DATA_W - 1; b >= 0; b--)
        exp_mosi.push_back(rd ? 1'b0 : wr_src[w][b]);
    if (rd) for (int w = 0; w <= len; w++) exp_rd.push_back(miso_mem[w]);
    cyc = 0; wr_pulses = 0; done_cnt = 0; done_cyc = -1; low_run = 0; max_low = 0;
    rd_pops = 0; rd_extra = 0; mosi_extra = 0; wr_take = 1'b0;
    wr_valid = (wr_src.size() > 0);
    wr_data  = (wr_src.size() > 0) ? wr_src[0] : '0;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    while (done_cnt == 0 && cyc < limit) step();
    step();
    chk("done_single_pulse", 32'(done_cnt), 32'd1);
    chk("idle_after_done", {29'd0, cmd_ready, busy, done}, 32'b100);
    chk("mosi_all_bits", 32'(exp_mosi.size()), 32'd0);
    chk("mosi_extra", 32'(mosi_extra), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 32; i++) miso_mem[i] = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_spi_clk",    32'(spi_clk),    32'd0);
    chk("rst_serial_out", 32'(serial_out), 32'd0);
    chk("rst_wr_ready",   32'(wr_ready),   32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    chk("rst_rd_valid",   32'(rd_valid),   32'd0);
    chk("rst_rd_count",   32'(rd_count),   32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Write burst: 0x3C then A5 5A FF; done at 33*4 + 3 + 1
    wr_src = '{8'hA5, 8'h5A, 8'hFF};
    issue(1'b0, 8'h3C, 2);
    run_to_done(400);
    chk("wr_done_cycle", 32'(done_cyc), 32'd136);
    chk("wr_ready_pulses", 32'(wr_pulses), 32'd3);

    // Read burst: chip returns 01..04
    for (int i = 0; i < 4; i++) miso_mem[i] = DATA_W'(i + 1);
    issue(1'b1, 8'h10, 3);
    run_to_done(400);
    chk("rd_done_cycle", 32'(done_cyc), 32'd169);
    chk("rd_count_full", 32'(rd_count), 32'd4);
    rd_auto = 1'b1;
    repeat (6) step();
    rd_auto = 1'b0;
    chk("rd_pops", 32'(rd_pops), 32'd4);
    chk("rd_extra", 32'(rd_extra), 32'd0);
    chk("rd_count_drained", 32'(rd_count), 32'd0);

    // Write underrun: wr_valid withheld ahead of word 2
    wr_src = '{8'h11, 8'hC3, 8'h7E};
    hold_word = 1; hold_len = 20;
    issue(1'b0, 8'h55, 2);
    run_to_done(600);
    hold_word = -1; hold_len = 0;
    chk("underrun_sclk_low_20", 32'(max_low >= 20), 32'd1);
    chk("underrun_wr_pulses", 32'(wr_pulses), 32'd3);

    // FIFO backpressure: 8-word read into a 4-deep FIFO
    for (int i = 0; i < 8; i++) miso_mem[i] = DATA_W'(8'h80 + 8'(i * 17));
    issue(1'b1, 8'hA0, 7);
    while (rd_count != CNT_W'(4) && cyc < 1000) step();
    repeat (40) step();
    chk("bp_stall1_bits", 32'(bitpos), 32'd41);
    chk("bp_stall1_count", 32'(rd_count), 32'd4);
    chk("bp_stall1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 2; k++) begin chk_rd(); rd_ready = 1'b1; step(); end
    while (rd_count != CNT_W'(4) && cyc < 2000) step();
    repeat (40) step();
    chk("bp_stall2_bits", 32'(bitpos), 32'd57);
    chk("bp_stall2_count", 32'(rd_count), 32'd4);
    rd_auto = 1'b1;
    run_to_done(3000);
    repeat (6) step();
    rd_auto = 1'b0;
    chk("bp_rd_pops", 32'(rd_pops), 32'd8);
    chk("bp_rd_extra", 32'(rd_extra), 32'd0);
    chk("bp_rd_left", 32'(exp_rd.size()), 32'd0);

    // Max burst: 16 words
    for (int i = 0; i < MAX_BURST; i++) wr_src.push_back(DATA_W'($urandom_range(0, 255)));
    issue(1'b0, 8'h00, MAX_BURST - 1);
    run_to_done(1500);
    chk("max_wr_pulses", 32'(wr_pulses), 32'd16);
    chk("max_done_cycle", 32'(done_cyc), 32'd565);

    // Reset in the middle of a read word
    for (int i = 0; i < 4; i++) miso_mem[i] = DATA_W'(8'hC1 + 8'(i));
    issue(1'b1, 8'h22, 3);
    while (bitpos < 20 && cyc < 500) step();
    chk("mid_rd_count", 32'(rd_count), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_spi_clk",   32'(spi_clk),   32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_rd_count",  32'(rd_count),  32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_rd_valid",  32'(rd_valid),  32'd0);
    #2;
    rst = 1'b0;
    exp_mosi.delete();
    exp_rd.delete();
    @(posedge clk); #2;
    wr_src = '{8'h96, 8'h69};
    issue(1'b0, 8'h81, 1);
    run_to_done(400);
    chk("post_rst_done_cycle", 32'(done_cyc), 32'd103);
    chk("post_rst_wr_pulses", 32'(wr_pulses), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
